// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus controller slice: controller states, slot map,
// control-bus bit positions and BCD range limits.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_RST        = 3'b000,
    ST_INICIALIZA = 3'b001,
    ST_WAITING    = 3'b010,
    ST_LEE        = 3'b011,
    ST_EDITA      = 3'b100
  } rtc_state_e;

  localparam int unsigned N_SLOTS     = 9;
  localparam int unsigned SLOT_SEG    = 0;
  localparam int unsigned SLOT_MIN    = 1;
  localparam int unsigned SLOT_HORA   = 2;
  localparam int unsigned SLOT_DIA    = 3;
  localparam int unsigned SLOT_MES    = 4;
  localparam int unsigned SLOT_ANIO   = 5;
  localparam int unsigned SLOT_T_SEG  = 6;
  localparam int unsigned SLOT_T_MIN  = 7;
  localparam int unsigned SLOT_T_HORA = 8;
  localparam int unsigned POS_IDLE_C  = 9;

  localparam int unsigned CTRL_CS_BIT = 0;
  localparam int unsigned CTRL_RD_BIT = 1;
  localparam int unsigned CTRL_WR_BIT = 2;
  localparam int unsigned CTRL_AD_BIT = 3;

  localparam logic [7:0] LIM_MINSEG = 8'h59;
  localparam logic [7:0] LIM_HORA   = 8'h23;
  localparam logic [7:0] LIM_DIA    = 8'h31;
  localparam logic [7:0] LIM_MES    = 8'h12;
  localparam logic [7:0] LIM_ANIO   = 8'h99;

  function automatic logic [7:0] slot_min(input int unsigned s);
    case (s)
      SLOT_DIA, SLOT_MES: return 8'h01;
      default:            return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] slot_max(input int unsigned s);
    case (s)
      SLOT_SEG, SLOT_MIN, SLOT_T_SEG, SLOT_T_MIN: return LIM_MINSEG;
      SLOT_HORA, SLOT_T_HORA:                     return LIM_HORA;
      SLOT_DIA:                                   return LIM_DIA;
      SLOT_MES:                                   return LIM_MES;
      default:                                    return LIM_ANIO;
    endcase
  endfunction

  function automatic logic [7:0] slot_reset(input int unsigned s);
    case (s)
      SLOT_DIA, SLOT_MES: return 8'h01;
      default:            return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_rango.sv
// Combinational check: byte is packed BCD (both nibbles 0..9) and lies within [min_i, max_i].
module bcd_rango (
  input  logic [7:0] dato_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  output logic       ok_o
);

  // For valid BCD, plain binary ordering matches decimal ordering.
  always_comb begin
    ok_o = (dato_i[7:4] <= 4'd9) && (dato_i[3:0] <= 4'd9) &&
           (dato_i >= min_i) && (dato_i <= max_i);
  end

endmodule

// File: rtl/rtc_captura.sv
// Snoops RTC controller read cycles, collects nine BCD bytes into a shadow bank and
// commits them atomically at frame end when complete and in range.
module rtc_captura
  import rtc_pkg::*;
#(
  parameter int unsigned POS_IDLE = POS_IDLE_C,
  parameter int unsigned RD_BIT   = CTRL_RD_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic [3:0] control,
  input  logic [3:0] posicion,
  input  logic [7:0] dato_in,
  input  logic       ack_alarma,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora,
  output logic       dato_valido,
  output logic       error_bcd,
  output logic       alarma
);

  rtc_state_e       state_q;
  logic             rd_q;
  logic [8:0]       mask_q, mask_d;
  logic [7:0]       shadow_q [N_SLOTS];
  logic [7:0]       shadow_d [N_SLOTS];
  logic [7:0]       out_q    [N_SLOTS];
  logic [7:0]       out_d    [N_SLOTS];
  logic             dv_q, err_q, err_d, alarm_q, alarm_d;
  logic [8:0]       slot_ok;

  logic             in_lee, prev_lee, frame_start, frame_end;
  logic             rd_rise, pos_ok, capture, commit, reject;
  logic             timer_zero_new, timer_nz_old;
  logic             unused_ctrl;

  assign unused_ctrl = ^control;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_chk
    bcd_rango u_chk (
      .dato_i (shadow_q[g]),
      .min_i  (slot_min(g)),
      .max_i  (slot_max(g)),
      .ok_o   (slot_ok[g])
    );
  end

  always_comb begin
    in_lee      = (state == ST_LEE);
    prev_lee    = (state_q == ST_LEE);
    frame_start = in_lee && !prev_lee;
    frame_end   = (state == ST_WAITING) && prev_lee;
    rd_rise     = !rd_q && control[RD_BIT];
    pos_ok      = (32'(posicion) != POS_IDLE) && (posicion <= 4'(SLOT_T_HORA));
    capture     = rd_rise && in_lee && pos_ok;
    commit      = frame_end && (&mask_q) && (&slot_ok);
    reject      = frame_end && !commit;

    timer_zero_new = ({shadow_q[SLOT_T_HORA], shadow_q[SLOT_T_MIN], shadow_q[SLOT_T_SEG]} == '0);
    timer_nz_old   = |{out_q[SLOT_T_HORA], out_q[SLOT_T_MIN], out_q[SLOT_T_SEG]};

    // Clearing on frame start and capturing in the same cycle leaves only the new slot set.
    mask_d   = frame_start ? '0 : mask_q;
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (capture && (posicion == 4'(i))) begin
        shadow_d[i] = dato_in;
        mask_d[i]   = 1'b1;
      end
    end

    out_d = commit ? shadow_q : out_q;
    err_d = err_q | reject;

    if (commit && timer_zero_new && timer_nz_old) begin
      alarm_d = 1'b1;
    end else if (ack_alarma) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      rd_q    <= 1'b1;
      mask_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= slot_reset(i);
      end
    end else begin
      state_q  <= rtc_state_e'(state);
      rd_q     <= control[RD_BIT];
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      dv_q     <= commit;
      err_q    <= err_d;
      alarm_q  <= alarm_d;
    end
  end

  assign segundos    = out_q[SLOT_SEG];
  assign minutos     = out_q[SLOT_MIN];
  assign horas       = out_q[SLOT_HORA];
  assign dia         = out_q[SLOT_DIA];
  assign mes         = out_q[SLOT_MES];
  assign anio        = out_q[SLOT_ANIO];
  assign t_seg       = out_q[SLOT_T_SEG];
  assign t_min       = out_q[SLOT_T_MIN];
  assign t_hora      = out_q[SLOT_T_HORA];
  assign dato_valido = dv_q;
  assign error_bcd   = err_q;
  assign alarma      = alarm_q;

endmodule

// File: tb/tb_rtc_captura.sv
// Directed self-checking bench for rtc_captura: frames, rejects, aborts, alarm and reset.
module tb_rtc_captura;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic [3:0] control;
  logic [3:0] posicion;
  logic [7:0] dato_in;
  logic       ack_alarma;
  logic [7:0] segundos, minutos, horas, dia, mes, anio, t_seg, t_min, t_hora;
  logic       dato_valido, error_bcd, alarma;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fv  [9];
  logic [7:0] ev  [9];

  localparam logic [2:0] S_RST   = 3'b000;
  localparam logic [2:0] S_WAIT  = 3'b010;
  localparam logic [2:0] S_LEE   = 3'b011;
  localparam logic [2:0] S_EDITA = 3'b100;

  rtc_captura #(.POS_IDLE(9), .RD_BIT(1)) dut (
    .clk(clk), .reset(reset), .state(state), .control(control),
    .posicion(posicion), .dato_in(dato_in), .ack_alarma(ack_alarma),
    .segundos(segundos), .minutos(minutos), .horas(horas), .dia(dia),
    .mes(mes), .anio(anio), .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora),
    .dato_valido(dato_valido), .error_bcd(error_bcd), .alarma(alarma)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] out_at(input int i);
    case (i)
      0: return segundos;
      1: return minutos;
      2: return horas;
      3: return dia;
      4: return mes;
      5: return anio;
      6: return t_seg;
      7: return t_min;
      default: return t_hora;
    endcase
  endfunction

  task automatic chk_outs(input string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s.slot%0d", tag, i), out_at(i), ev[i]);
  endtask

  task automatic set_fv(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    fv[0] = a0; fv[1] = a1; fv[2] = a2; fv[3] = a3; fv[4] = a4;
    fv[5] = a5; fv[6] = a6; fv[7] = a7; fv[8] = a8;
  endtask

  task automatic set_ev(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    ev[0] = a0; ev[1] = a1; ev[2] = a2; ev[3] = a3; ev[4] = a4;
    ev[5] = a5; ev[6] = a6; ev[7] = a7; ev[8] = a8;
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic rd_pulse(input logic [3:0] p, input logic [7:0] d);
    posicion   = p;
    dato_in    = d;
    control[1] = 1'b0;
    @(negedge clk);
    control[1] = 1'b1;
    @(negedge clk);
    posicion   = 4'd9;
  endtask

  // Enter lee, pulse the enabled slots from fv, leave to end_st; returns after the decision edge.
  task automatic run_frame(input logic [8:0] en, input logic [2:0] end_st);
    state = S_LEE;
    @(negedge clk);
    for (int i = 0; i < 9; i++) if (en[i]) rd_pulse(4'(i), fv[i]);
    state = end_st;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; state = S_RST; control = 4'hF; posicion = 4'd9; ack_alarma = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; state = S_RST; control = 4'hF; posicion = 4'd9;
    dato_in = '0; ack_alarma = 1'b0;
    #12;
    set_ev(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_outs("reset");
    chk("reset.dv", 8'(dato_valido), 8'h0);
    chk("reset.err", 8'(error_bcd), 8'h0);
    chk("reset.alarm", 8'(alarma), 8'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Full valid frame, timer 00:00:10
    set_fv(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h10, 8'h00, 8'h00);
    run_frame(9'h1FF, S_WAIT);
    set_ev(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h10, 8'h00, 8'h00);
    chk_outs("f1");
    chk("f1.dv", 8'(dato_valido), 8'h1);
    chk("f1.err", 8'(error_bcd), 8'h0);
    chk("f1.alarm", 8'(alarma), 8'h0);
    @(negedge clk);
    chk("f1.dv_pulse_end", 8'(dato_valido), 8'h0);

    // Timer drops to zero: alarm
    set_fv(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00);
    run_frame(9'h1FF, S_WAIT);
    chk("f2.dv", 8'(dato_valido), 8'h1);
    chk("f2.t_seg", t_seg, 8'h00);
    chk("f2.alarm", 8'(alarma), 8'h1);
    ack_alarma = 1'b1;
    @(negedge clk);
    ack_alarma = 1'b0;
    chk("ack.alarm", 8'(alarma), 8'h0);

    // Zero again from zero: no alarm
    run_frame(9'h1FF, S_WAIT);
    chk("f3.dv", 8'(dato_valido), 8'h1);
    chk("f3.alarm", 8'(alarma), 8'h0);

    // Idle position pulse ignored, duplicate slot 1 last-write-wins
    state = S_LEE;
    @(negedge clk);
    rd_pulse(4'd1, 8'h11);
    rd_pulse(4'd9, 8'h77);
    rd_pulse(4'd0, 8'h45);
    rd_pulse(4'd2, 8'h12);
    rd_pulse(4'd3, 8'h15);
    rd_pulse(4'd4, 8'h08);
    rd_pulse(4'd5, 8'h24);
    rd_pulse(4'd6, 8'h05);
    rd_pulse(4'd7, 8'h00);
    rd_pulse(4'd8, 8'h00);
    rd_pulse(4'd1, 8'h22);
    state = S_WAIT;
    @(negedge clk);
    set_ev(8'h45, 8'h22, 8'h12, 8'h15, 8'h08, 8'h24, 8'h05, 8'h00, 8'h00);
    chk_outs("dup");
    chk("dup.dv", 8'(dato_valido), 8'h1);
    chk("dup.err", 8'(error_bcd), 8'h0);

    // Set and ack in the same cycle: set wins
    set_fv(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00);
    ack_alarma = 1'b1;
    run_frame(9'h1FF, S_WAIT);
    chk("f5.alarm_setwins", 8'(alarma), 8'h1);
    ack_alarma = 1'b0;
    @(negedge clk);
    chk("f5.alarm_hold", 8'(alarma), 8'h1);
    ack_alarma = 1'b1;
    @(negedge clk);
    ack_alarma = 1'b0;
    chk("f5.alarm_ack", 8'(alarma), 8'h0);

    // Missing slot 4: reject, outputs keep last commit
    set_fv(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    run_frame(9'h1EF, S_WAIT);
    set_ev(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00);
    chk_outs("miss4");
    chk("miss4.dv", 8'(dato_valido), 8'h0);
    chk("miss4.err", 8'(error_bcd), 8'h1);

    // Upper boundaries accepted; error stays sticky
    set_fv(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h23);
    run_frame(9'h1FF, S_WAIT);
    set_ev(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h23);
    chk_outs("max");
    chk("max.dv", 8'(dato_valido), 8'h1);
    chk("max.err_sticky", 8'(error_bcd), 8'h1);

    // Abort: lee -> edita discards silently
    do_reset();
    set_fv(8'h45, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h10, 8'h00, 8'h00);
    run_frame(9'h1FF, S_EDITA);
    chk("abort.dv", 8'(dato_valido), 8'h0);
    chk("abort.err", 8'(error_bcd), 8'h0);
    chk("abort.seg", segundos, 8'h00);
    state = S_WAIT;
    @(negedge clk);
    chk("abort.err_after", 8'(error_bcd), 8'h0);

    // Commit, then reset mid-frame after 5 captures, then a fresh frame
    run_frame(9'h1FF, S_WAIT);
    chk("pre.seg", segundos, 8'h45);
    state = S_LEE;
    @(negedge clk);
    for (int i = 0; i < 5; i++) rd_pulse(4'(i), 8'h33);
    reset = 1'b0;
    #1;
    set_ev(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    chk_outs("midrst");
    chk("midrst.dv", 8'(dato_valido), 8'h0);
    @(negedge clk);
    state = S_RST;
    reset = 1'b1;
    @(negedge clk);
    set_fv(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    run_frame(9'h1FF, S_WAIT);
    set_ev(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    chk_outs("post");
    chk("post.dv", 8'(dato_valido), 8'h1);

    // Out-of-range single slots
    do_reset();
    set_fv(8'h5A, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h10, 8'h00, 8'h00);
    run_frame(9'h1FF, S_WAIT);
    chk("seg5A.err", 8'(error_bcd), 8'h1);
    chk("seg5A.dv", 8'(dato_valido), 8'h0);
    chk("seg5A.seg", segundos, 8'h00);

    do_reset();
    set_fv(8'h45, 8'h30, 8'h24, 8'h15, 8'h08, 8'h24, 8'h10, 8'h00, 8'h00);
    run_frame(9'h1FF, S_WAIT);
    chk("hora24.err", 8'(error_bcd), 8'h1);
    chk("hora24.horas", horas, 8'h00);

    do_reset();
    set_fv(8'h45, 8'h30, 8'h12, 8'h15, 8'h00, 8'h24, 8'h10, 8'h00, 8'h00);
    run_frame(9'h1FF, S_WAIT);
    chk("mes00.err", 8'(error_bcd), 8'h1);
    chk("mes00.mes", mes, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_captura.md
# rtc_captura

Downstream stage of the RTC bus controller. It snoops the controller's read cycles (`posicion`, `control`, `state`) together with the data bus returned by the RTC chip, and collects the nine time, date and timer bytes into a shadow bank. At the end of each read frame it checks every byte for BCD format and range. If the frame is complete and valid, it commits the bytes atomically to stable output registers for the VGA display path, and it raises a timer-expiry alarm.

## Interface
Parameters
- `POS_IDLE`, 9: `posicion` value meaning "no register being read".
- `RD_BIT`, 1: index of the active-low RD strobe within `control`.

Ports
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `state`  in  3  controller state; `3'b011` = lee, `3'b010` = waiting.
- `control`  in  4  controller bus control; bit `RD_BIT` = RD_n.
- `posicion`  in  4  slot being read: 0..8, or `POS_IDLE`.
- `dato_in`  in  8  data bus from the RTC chip.
- `ack_alarma`  in  1  clears `alarma`.
- `segundos`, `minutos`, `horas`, `dia`, `mes`, `anio`  out  8 each  committed date/time, BCD.
- `t_seg`, `t_min`, `t_hora`  out  8 each  committed timer, BCD.
- `dato_valido`  out  1  one-cycle pulse on each commit.
- `error_bcd`  out  1  sticky; set when a frame is rejected.
- `alarma`  out  1  timer reached 00:00:00.

## Operation
- Slot map: 0 seg, 1 min, 2 hora, 3 dia, 4 mes, 5 anio, 6 t_seg, 7 t_min, 8 t_hora.
- Edge detection: register `state` and `control[RD_BIT]` each cycle.
- Frame start: on the cycle `state` becomes lee (previous value was not lee), clear the 9-bit written mask.
- Capture: on an RD_n rising edge (registered value 0, current value 1) while `state` is lee and `posicion` ≤ 8:
  - `shadow[posicion] <= dato_in`.
  - Set `mask[posicion]`.
  - Capture ignores a `posicion` of 9..15.
  - A repeated slot overwrites the earlier value; the last write wins.
- Frame end: on the lee -> waiting transition, commit when the mask is all ones and every slot passes its check:
  - Each nibble must be ≤ 9.
  - seg, min, t_seg, t_min must be ≤ 0x59.
  - hora, t_hora must be ≤ 0x23.
  - dia must be 0x01..0x31.
  - mes must be 0x01..0x12.
  - anio may be any valid BCD.
- Commit copies all nine bytes in the same cycle and pulses `dato_valido`.
- Reject: when the mask is incomplete or any check fails, outputs keep their previous values and `error_bcd` sets. `error_bcd` clears only on reset.
- Abort: when lee exits to any state other than waiting, the frame is discarded silently. No commit, no error.
- Alarm: at commit, `alarma` sets when the new timer value is 00:00:00 and the previously committed timer value was nonzero.
  - `ack_alarma` clears `alarma`.
  - When set and clear occur in the same cycle, set wins.

## Timing
- Reset values: all BCD outputs 0x00 except `dia` = 0x01 and `mes` = 0x01. `dato_valido`, `error_bcd` and `alarma` are 0. Mask and shadow are 0.
- Capture latency: `dato_in` present on the RD_n rising-edge cycle is in the shadow bank on the next edge.
- Commit latency: outputs and `dato_valido` update on the edge after the cycle in which the lee -> waiting transition is seen (`state` is waiting and the registered state is lee). The pulse lasts exactly 1 cycle.
- `alarma` and `error_bcd` update on the same edge as the commit or reject decision.
- Reset asserted mid-frame clears everything immediately. The next frame starts from an empty mask.
- A capture edge coincident with the frame-end cycle is not accepted; `state` is already waiting.

## Structure
- Shared package `rtc_pkg` holds:
  - state encodings (rst, inicializa, waiting, lee, edita);
  - slot indices 0..8 and `POS_IDLE`;
  - control bit indices;
  - BCD range limits (0x59, 0x23, 0x31, 0x12).
- Sub-module `bcd_rango`: combinational check of one byte against (min, max). Instantiate nine copies, or one per slot type.

## Test plan
- Full frame, 9 RD pulses with slots 0..8 = 0x45, 0x30, 0x12, 0x15, 0x08, 0x24, 0x10, 0x00, 0x00, then lee -> waiting -> outputs hold exactly those values, `dato_valido` high for 1 cycle, `error_bcd` = 0.
- Frame missing slot 4 -> outputs unchanged from the prior commit, `error_bcd` = 1, no `dato_valido`.
- Slot 0 = 0x5A, or slot 2 = 0x24, or slot 4 = 0x00 -> frame rejected, `error_bcd` = 1.
- Timer committed 00:00:10, then a frame with 00:00:00 -> `alarma` = 1. Assert `ack_alarma` -> 0. A further 00:00:00 frame leaves `alarma` = 0.
- `reset` low mid-frame after 5 captures, then release and run a full valid frame -> outputs return to reset values, then take the new values, with no stale shadow data.
- `posicion` = 9 during an RD pulse, plus a duplicate slot 1 (0x11, then 0x22) -> idle pulse ignored, `minutos` = 0x22 after commit.
